// File: rtl/hazard_unit_if.sv
// Hazard unit bundle: Decode/Execute/Mem/WB register addresses and controls in,
// stall/flush/forward selects and event counters out.
interface hazard_unit_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic              RegWriteM, RegWriteW, MemtoRegE;
    logic              PCWrPendingF, PCSrcW, BranchTakenE, clr_cnt;
    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE,
        output PCWrPendingF, PCSrcW, BranchTakenE, clr_cnt,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE,
        input  PCWrPendingF, PCSrcW, BranchTakenE, clr_cnt,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: M/W operand forwarding, multi-cycle load-use stall
// sequencer with branch-over-stall priority, saturating stall/flush counters.
module hazard_unit #(
    parameter int REG_AW   = 4,
    parameter int PC_REG   = 15,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_unit_if.slave hz
);
    localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);
    localparam int                REM_W  = 4;

    typedef enum logic {IDLE, LDSTALL} state_t;

    state_t                 state;
    logic [REM_W-1:0]       rem;
    logic                   ldhit, ldstall;
    logic [CNT_W-1:0]       stallCnt, flushCnt;
    logic [1:0][REG_AW-1:0] srcE;
    logic [1:0][1:0]        fwd;

    // Operand 0 is SrcA, operand 1 is SrcB; M beats W, PC is never forwarded.
    assign srcE = {hz.RA2E, hz.RA1E};
    for (genvar g = 0; g < 2; g++) begin : g_fwd
        logic mHit, wHit;
        assign mHit   = hz.RegWriteM && (hz.WA3M == srcE[g]) && (srcE[g] != PC_IDX);
        assign wHit   = hz.RegWriteW && (hz.WA3W == srcE[g]) && (srcE[g] != PC_IDX);
        assign fwd[g] = !reset ? 2'b00 : mHit ? 2'b10 : wHit ? 2'b01 : 2'b00;
    end
    assign hz.ForwardAE = fwd[0];
    assign hz.ForwardBE = fwd[1];

    assign ldhit   = hz.MemtoRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    // A taken branch squashes the wrong-path Decode instruction, so it kills the stall.
    assign ldstall = reset && !hz.BranchTakenE &&
                     (((state == IDLE) && ldhit) || (state == LDSTALL));

    assign hz.StallD = ldstall;
    assign hz.StallF = ldstall || (reset && hz.PCWrPendingF);
    assign hz.FlushE = ldstall || (reset && hz.BranchTakenE);
    assign hz.FlushD = reset && (hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ldhit && !hz.BranchTakenE && (LOAD_LAT > 1)) begin
                        state <= LDSTALL;
                        rem   <= REM_W'(LOAD_LAT - 1);
                    end
                end
                LDSTALL: begin
                    if (hz.BranchTakenE || (rem == REM_W'(1))) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else begin
                        rem <= rem - REM_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (hz.clr_cnt) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (ldstall && (stallCnt != '1))
                stallCnt <= stallCnt + CNT_W'(1);
            if (hz.BranchTakenE && (flushCnt != '1))
                flushCnt <= flushCnt + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stallCnt;
    assign hz.flush_cnt = flushCnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=2) share one stimulus set; flags are checked as {StallF,StallD,FlushD,FlushE}.
module tb_hazard_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE, clrCnt;
    int         nCmp = 0;
    int         nBad = 0;

    always #5 clk = ~clk;

    hazard_unit_if #(.REG_AW(4), .CNT_W(16)) ifA ();
    hazard_unit_if #(.REG_AW(4), .CNT_W(16)) ifB ();
    hazard_unit_if #(.REG_AW(4), .CNT_W(2))  ifC ();

    assign ifA.RA1D = RA1D; assign ifA.RA2D = RA2D; assign ifA.RA1E = RA1E; assign ifA.RA2E = RA2E;
    assign ifA.WA3E = WA3E; assign ifA.WA3M = WA3M; assign ifA.WA3W = WA3W;
    assign ifA.RegWriteM = RegWriteM; assign ifA.RegWriteW = RegWriteW; assign ifA.MemtoRegE = MemtoRegE;
    assign ifA.PCWrPendingF = PCWrPendingF; assign ifA.PCSrcW = PCSrcW;
    assign ifA.BranchTakenE = BranchTakenE; assign ifA.clr_cnt = clrCnt;

    assign ifB.RA1D = RA1D; assign ifB.RA2D = RA2D; assign ifB.RA1E = RA1E; assign ifB.RA2E = RA2E;
    assign ifB.WA3E = WA3E; assign ifB.WA3M = WA3M; assign ifB.WA3W = WA3W;
    assign ifB.RegWriteM = RegWriteM; assign ifB.RegWriteW = RegWriteW; assign ifB.MemtoRegE = MemtoRegE;
    assign ifB.PCWrPendingF = PCWrPendingF; assign ifB.PCSrcW = PCSrcW;
    assign ifB.BranchTakenE = BranchTakenE; assign ifB.clr_cnt = clrCnt;

    assign ifC.RA1D = RA1D; assign ifC.RA2D = RA2D; assign ifC.RA1E = RA1E; assign ifC.RA2E = RA2E;
    assign ifC.WA3E = WA3E; assign ifC.WA3M = WA3M; assign ifC.WA3W = WA3W;
    assign ifC.RegWriteM = RegWriteM; assign ifC.RegWriteW = RegWriteW; assign ifC.MemtoRegE = MemtoRegE;
    assign ifC.PCWrPendingF = PCWrPendingF; assign ifC.PCSrcW = PCSrcW;
    assign ifC.BranchTakenE = BranchTakenE; assign ifC.clr_cnt = clrCnt;

    hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_LAT(1), .CNT_W(16)) uLat1 (.clk(clk), .reset(reset), .hz(ifA));
    hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_LAT(3), .CNT_W(16)) uLat3 (.clk(clk), .reset(reset), .hz(ifB));
    hazard_unit #(.REG_AW(4), .PC_REG(15), .LOAD_LAT(1), .CNT_W(2))  uSat  (.clk(clk), .reset(reset), .hz(ifC));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE, clrCnt} = '0;
    endtask

    task automatic setLdHit;
        MemtoRegE = 1'b1; WA3E = 4'd2; RA2D = 4'd2; RA1D = 4'd0;
    endtask

    task automatic clearCounters;
        clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
    endtask

    task automatic test_reset;
        clearInputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        setLdHit();
        PCWrPendingF = 1'b1; BranchTakenE = 1'b1;
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
        #2;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL reset_flags got=%b exp=0000", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        nCmp++; if (ifA.ForwardAE !== 2'b00) begin
            nBad++; $display("FAIL reset_fwd got=%b exp=00", ifA.ForwardAE); end
        nCmp++; if (ifA.stall_cnt !== 16'd0 || ifA.flush_cnt !== 16'd0) begin
            nBad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ifA.stall_cnt, ifA.flush_cnt); end
        clearInputs();
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_forward;
        clearInputs();
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA2E = 4'd5;
        #2;
        nCmp++; if (ifA.ForwardAE !== 2'b10) begin nBad++; $display("FAIL fwdA_MoverW got=%b exp=10", ifA.ForwardAE); end
        nCmp++; if (ifA.ForwardBE !== 2'b00) begin nBad++; $display("FAIL fwdB_none got=%b exp=00", ifA.ForwardBE); end
        RegWriteM = 1'b0;
        #2;
        nCmp++; if (ifA.ForwardAE !== 2'b01) begin nBad++; $display("FAIL fwdA_W got=%b exp=01", ifA.ForwardAE); end
        RA2E = 4'd3;
        #2;
        nCmp++; if (ifA.ForwardBE !== 2'b01) begin nBad++; $display("FAIL fwdB_W got=%b exp=01", ifA.ForwardBE); end
        RegWriteM = 1'b1;
        #2;
        nCmp++; if (ifA.ForwardBE !== 2'b10) begin nBad++; $display("FAIL fwdB_M got=%b exp=10", ifA.ForwardBE); end
        RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15;
        #2;
        nCmp++; if (ifA.ForwardAE !== 2'b00) begin nBad++; $display("FAIL fwdA_pc got=%b exp=00", ifA.ForwardAE); end
        RA1E = 4'd3; WA3M = 4'd7; RegWriteW = 1'b0; WA3W = 4'd3;
        #2;
        nCmp++; if (ifA.ForwardAE !== 2'b00) begin nBad++; $display("FAIL fwdA_wen_off got=%b exp=00", ifA.ForwardAE); end
        clearInputs();
        step();
    endtask

    task automatic test_load_lat;
        clearCounters();
        setLdHit();
        #1;
        nCmp++; if ({ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE} !== 4'b1101) begin
            nBad++; $display("FAIL lat1_stall got=%b exp=1101", {ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE}); end
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b1101) begin
            nBad++; $display("FAIL lat3_c0 got=%b exp=1101", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        step();
        clearInputs();
        #1;
        nCmp++; if ({ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL lat1_release got=%b exp=0000", {ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE}); end
        nCmp++; if (ifA.stall_cnt !== 16'd1) begin nBad++; $display("FAIL lat1_cnt got=%0d exp=1", ifA.stall_cnt); end
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b1101) begin
            nBad++; $display("FAIL lat3_c1 got=%b exp=1101", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        step(); #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b1101) begin
            nBad++; $display("FAIL lat3_c2 got=%b exp=1101", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        step(); #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL lat3_c3 got=%b exp=0000", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        nCmp++; if (ifB.stall_cnt !== 16'd3) begin nBad++; $display("FAIL lat3_cnt got=%0d exp=3", ifB.stall_cnt); end
        step();
    endtask

    task automatic test_back_to_back;
        clearCounters();
        setLdHit();
        for (int k = 0; k < 4; k++) begin
            #1;
            nCmp++; if (ifB.StallD !== 1'b1) begin nBad++; $display("FAIL b2b_held c%0d got=%b exp=1", k, ifB.StallD); end
            step();
        end
        clearInputs();
        for (int k = 4; k < 7; k++) begin
            #1;
            nCmp++; if (ifB.StallD !== (k < 6)) begin nBad++; $display("FAIL b2b_tail c%0d got=%b exp=%b", k, ifB.StallD, k < 6); end
            step();
        end
        nCmp++; if (ifB.stall_cnt !== 16'd6) begin nBad++; $display("FAIL b2b_cnt got=%0d exp=6", ifB.stall_cnt); end
    endtask

    task automatic test_branch_abort;
        clearCounters();
        setLdHit();
        step();
        clearInputs();
        BranchTakenE = 1'b1;
        #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0011) begin
            nBad++; $display("FAIL abort_flags got=%b exp=0011", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        step();
        BranchTakenE = 1'b0;
        #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL abort_idle got=%b exp=0000", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        nCmp++; if (ifB.flush_cnt !== 16'd1 || ifB.stall_cnt !== 16'd1) begin
            nBad++; $display("FAIL abort_cnt got=%0d/%0d exp=1/1", ifB.flush_cnt, ifB.stall_cnt); end
        setLdHit();
        BranchTakenE = 1'b1;
        #1;
        nCmp++; if ({ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE} !== 4'b0011) begin
            nBad++; $display("FAIL branch_beats_ld got=%b exp=0011", {ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE}); end
        step();
        clearInputs();
        #1;
        nCmp++; if (ifB.StallD !== 1'b0) begin nBad++; $display("FAIL branch_beats_ld_next got=%b exp=0", ifB.StallD); end
        step();
    endtask

    task automatic test_pcwrite;
        clearInputs();
        PCWrPendingF = 1'b1;
        #1;
        nCmp++; if ({ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE} !== 4'b1010) begin
            nBad++; $display("FAIL pcwr_pending got=%b exp=1010", {ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE}); end
        PCWrPendingF = 1'b0; PCSrcW = 1'b1;
        #1;
        nCmp++; if ({ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE} !== 4'b0010) begin
            nBad++; $display("FAIL pcsrcw got=%b exp=0010", {ifA.StallF, ifA.StallD, ifA.FlushD, ifA.FlushE}); end
        clearInputs();
        step();
    endtask

    task automatic test_saturate;
        clearCounters();
        setLdHit();
        for (int k = 1; k <= 5; k++) begin
            step();
            nCmp++; if (ifC.stall_cnt !== 2'((k > 3) ? 3 : k)) begin
                nBad++; $display("FAIL sat_cnt ev%0d got=%0d exp=%0d", k, ifC.stall_cnt, (k > 3) ? 3 : k); end
        end
        clrCnt = 1'b1;
        step();
        clrCnt = 1'b0;
        clearInputs();
        nCmp++; if (ifC.stall_cnt !== 2'd0) begin nBad++; $display("FAIL sat_clr got=%0d exp=0", ifC.stall_cnt); end
        step();
        nCmp++; if (ifC.stall_cnt !== 2'd0) begin nBad++; $display("FAIL sat_clr_hold got=%0d exp=0", ifC.stall_cnt); end
    endtask

    task automatic test_reset_mid;
        clearCounters();
        setLdHit();
        step();
        clearInputs();
        #1;
        nCmp++; if (ifB.StallD !== 1'b1) begin nBad++; $display("FAIL rmid_pre got=%b exp=1", ifB.StallD); end
        reset = 1'b0;
        PCWrPendingF = 1'b1;
        #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL rmid_async got=%b exp=0000", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        nCmp++; if (ifB.stall_cnt !== 16'd0) begin nBad++; $display("FAIL rmid_cnt got=%0d exp=0", ifB.stall_cnt); end
        PCWrPendingF = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        nCmp++; if ({ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE} !== 4'b0000) begin
            nBad++; $display("FAIL rmid_release got=%b exp=0000", {ifB.StallF, ifB.StallD, ifB.FlushD, ifB.FlushE}); end
        step(); #1;
        nCmp++; if (ifB.StallD !== 1'b0 || ifB.stall_cnt !== 16'd0) begin
            nBad++; $display("FAIL rmid_residual got=%b/%0d exp=0/0", ifB.StallD, ifB.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_lat();
        test_back_to_back();
        test_branch_abort();
        test_pcwrite();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised hazard unit for the 5-stage pipelined ARM core; sits beside controller and datapath inside the core top.
- Drives StallF/StallD/FlushD/FlushE/ForwardAE/ForwardBE, which the core top currently ties to defaults.
- Generalises hazard handling with:
  - a configurable register-address width;
  - a multi-cycle load-use stall sequencer for slow data memory;
  - branch-over-stall priority;
  - saturating stall and flush event counters for testbench and performance observation.

Parameters:
- REG_AW, 4, register address width.
- PC_REG, 15, register index never forwarded (PC).
- LOAD_LAT, 1, total load-use stall cycles (1..15); 1 equals the classic single bubble.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- RA1D  in  REG_AW  Decode source register 1.
- RA2D  in  REG_AW  Decode source register 2.
- RA1E  in  REG_AW  Execute source register 1.
- RA2E  in  REG_AW  Execute source register 2.
- WA3E  in  REG_AW  Execute destination register.
- WA3M  in  REG_AW  Memory-stage destination register.
- WA3W  in  REG_AW  Writeback destination register.
- RegWriteM  in  1  Memory-stage register write enable.
- RegWriteW  in  1  Writeback register write enable.
- MemtoRegE  in  1  Execute instruction is a load.
- PCWrPendingF  in  1  PCSrcD | PCSrcE | PCSrcM.
- PCSrcW  in  1  PC write in Writeback.
- BranchTakenE  in  1  branch resolved taken in Execute.
- clr_cnt  in  1  synchronous clear of both counters.
- StallF  out  1  hold PC register.
- StallD  out  1  hold Fetch/Decode register.
- FlushD  out  1  clear Fetch/Decode register.
- FlushE  out  1  clear Decode/Execute register.
- ForwardAE  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUOutM.
- ForwardBE  out  2  SrcB select, same encoding.
- stall_cnt  out  CNT_W  cycles with StallD=1.
- flush_cnt  out  CNT_W  cycles with BranchTakenE=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, remaining-cycle counter=0, stall_cnt=0, flush_cnt=0.
  - All hazard outputs forced to 0 while reset is low.
- Forwarding (combinational, same cycle), per operand X in {A,B}, source RXE:
  - 10 if RegWriteM && WA3M==RXE && RXE!=PC_REG;
  - else 01 if RegWriteW && WA3W==RXE && RXE!=PC_REG;
  - else 00.
  - M has priority over W when both match.
- Load-use detect: ldhit = MemtoRegE && (WA3E==RA1D || WA3E==RA2D).
- FSM states: IDLE, LDSTALL.
  - IDLE:
    - ldhit && !BranchTakenE: assert the stall this cycle.
    - If LOAD_LAT>1, go to LDSTALL with rem=LOAD_LAT-1; otherwise stay IDLE.
  - LDSTALL:
    - Stall asserted every cycle.
    - rem decrements each cycle; at rem==1, return to IDLE next cycle.
    - BranchTakenE=1 aborts: rem=0, go to IDLE, stall deasserted that same cycle.
- ldstall = (IDLE && ldhit && !BranchTakenE) || (LDSTALL && !BranchTakenE).
- Hazard outputs:
  - StallD = ldstall.
  - StallF = ldstall || PCWrPendingF.
  - FlushE = ldstall || BranchTakenE.
  - FlushD = PCWrPendingF || PCSrcW || BranchTakenE.
- Simultaneous events:
  - Branch beats load-use, since the Decode instruction is wrong-path.
  - StallD and FlushD are never both 1 in a cycle in which BranchTakenE=1.
- Total stall for one load-use event is exactly LOAD_LAT cycles; back-to-back loads re-trigger from IDLE.
- Counters (registered):
  - +1 on each clk with the respective condition true; saturate at all-ones, no wrap.
  - clr_cnt has priority over increment; counters read 0 on the next cycle.
- Reset mid-LDSTALL: immediate return to IDLE; outputs drop to 0 asynchronously.

Test Plan:
- RegWriteM=1, WA3M=3, RA1E=3, RegWriteW=1, WA3W=3 -> ForwardAE=10. RA1E=PC_REG=15 with WA3M=15 -> ForwardAE=00.
- LOAD_LAT=1: MemtoRegE=1, WA3E=2, RA2D=2 for one cycle -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt=1.
- LOAD_LAT=3: same stimulus, inputs deasserted after first cycle -> stall held 3 cycles, then all 0; stall_cnt=3.
- LOAD_LAT=3: BranchTakenE=1 in second stall cycle -> that cycle StallD=0, FlushD=FlushE=1; next cycle IDLE; flush_cnt=1.
- CNT_W=2: five ldhit events -> stall_cnt saturates at 3; clr_cnt=1 -> 0 next cycle.
- Drop reset to 0 during LDSTALL -> all outputs 0 immediately; after release, no residual stall.
